seq_divider: RTL

//   Iterative unsigned restoring divider. It retires one quotient bit per clock using a
//   (WIDTH+1)-bit subtract-with-borrow datapath. It is the subtraction/inverse counterpart
//   to the ripple adder in the ALU and serves as the multi-cycle DIV/REM unit beside it.
//   The ALU control FSM drives it through a Start/Busy/Done handshake.

---
 rtl/div_pkg.sv | 15 +
 rtl/sub_borrow.sv | 30 +++
 rtl/seq_divider.sv | 118 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_t : control FSM state encoding (IDLE, RUN, DONE)
//   DIV_ZERO_Q  : quotient reported for a zero divisor (all ones); 64 bits wide
//                 so any divider up to WIDTH=64 can take its low WIDTH bits.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [63:0] DIV_ZERO_Q = '1;

endpackage : div_pkg

// File: rtl/sub_borrow.sv
// Ripple subtract-with-borrow: Diff = A - B (mod 2**W), BorrowOut = 1 when A < B.
// Built as a chain of 1-bit full subtractors, the mirror of the ALU's full-adder chain.
// Ports:
//   A, B       in   W  minuend, subtrahend
//   Diff       out  W  difference
//   BorrowOut  out  1  borrow out of the most significant stage
module sub_borrow #(
  parameter int W = 33
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Diff,
  output logic         BorrowOut
);

  // borrowChain[i] is the borrow into stage i; no borrow enters stage 0.
  logic [W:0] borrowChain;

  assign borrowChain[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : gStage
    assign Diff[i]          = A[i] ^ B[i] ^ borrowChain[i];
    // Borrow when the subtrahend bit beats the minuend bit, or when they are
    // equal and a borrow is already propagating in.
    assign borrowChain[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrowChain[i]);
  end

  assign BorrowOut = borrowChain[W];

endmodule : sub_borrow

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// Driven through a Start/Busy/Done handshake by the ALU control FSM.
// Ports:
//   Clk        in   1      rising-edge clock
//   ResetN     in   1      synchronous active-low reset
//   Start      in   1      request; accepted only in IDLE or DONE
//   DataA      in   WIDTH  dividend, captured on accepted Start
//   DataB      in   WIDTH  divisor, captured on accepted Start
//   Busy       out  1      operation in progress
//   Done       out  1      one-cycle pulse, results valid
//   DivByZero  out  1      valid with Done: captured divisor was zero
//   Quotient   out  WIDTH  held from Done until the next accepted Start
//   Remainder  out  WIDTH  held from Done until the next accepted Start
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  div_state_t       state;
  logic [WIDTH-1:0] qReg;      // dividend shifting out, quotient shifting in
  logic [WIDTH:0]   rReg;      // partial remainder
  logic [WIDTH:0]   dReg;      // zero-extended divisor
  logic [CNT_W-1:0] cnt;       // iterations left
  logic             zeroPend;  // accepted op had a zero divisor

  logic [WIDTH:0]   rShift;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   rNext;
  logic [WIDTH-1:0] qNext;
  logic             borrow;
  logic             accept;
  logic             unusedRegMsb;

  // Bring the next dividend bit into the partial remainder, then trial-subtract.
  assign rShift = {rReg[WIDTH-1:0], qReg[WIDTH-1]};

  sub_borrow #(.W(WIDTH + 1)) uSub (
    .A        (rShift),
    .B        (dReg),
    .Diff     (diff),
    .BorrowOut(borrow)
  );

  // Restore on borrow; otherwise keep the difference and retire a 1.
  assign rNext = borrow ? rShift : diff;
  assign qNext = {qReg[WIDTH-2:0], ~borrow};

  assign accept = Start && (state == IDLE || state == DONE);

  // The remainder never exceeds the divisor, so its top bit is never shifted on.
  assign unusedRegMsb = rReg[WIDTH];

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and not in the sensitivity list; it also abandons an operation in flight.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      // NOTE: non-blocking assignments for every register so all state
      // updates use the values from before the edge, regardless of order.
      state     <= IDLE;
      qReg      <= '0;
      rReg      <= '0;
      dReg      <= '0;
      cnt       <= '0;
      zeroPend  <= 1'b0;
      DivByZero <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
    end else if (accept) begin
      qReg      <= DataA;
      dReg      <= {1'b0, DataB};
      rReg      <= '0;
      cnt       <= CNT_W'(WIDTH);
      zeroPend  <= (DataB == '0);
      DivByZero <= 1'b0;
      state     <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (zeroPend) begin
            // Zero divisor: one RUN cycle, no iterations; dividend is still in qReg.
            Quotient  <= DIV_ZERO_Q[WIDTH-1:0];
            Remainder <= qReg;
            DivByZero <= 1'b1;
            state     <= DONE;
          end else begin
            qReg <= qNext;
            rReg <= rNext;
            cnt  <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              Quotient  <= qNext;
              Remainder <= rNext[WIDTH-1:0];
              state     <= DONE;
            end
          end
        end
        IDLE, DONE: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule : seq_divider
